// File: rtl/unibus_mem_slave_pkg.sv
// Shared definitions for the Unibus slave memory: bus control codes,
// the ARM-visible ID word, the I/O-page address prefix and the FSM states.
package unibus_mem_slave_pkg;

  localparam logic [1:0] CTL_DATI  = 2'd0;
  localparam logic [1:0] CTL_DATIP = 2'd1;
  localparam logic [1:0] CTL_DATO  = 2'd2;
  localparam logic [1:0] CTL_DATOB = 2'd3;

  localparam logic [31:0] ID_VALUE = 32'h554D1005;
  localparam logic [31:0] BAD_REG  = 32'hDEADBEEF;

  // a_in_h[17:13] value of the Unibus I/O page; never answered by memory
  localparam logic [4:0] IO_PAGE = 5'b11111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DESKEW,
    S_ACCESS,
    S_SETUP,
    S_REPLY,
    S_ARMDONE
  } state_e;

endpackage

// File: rtl/unibus_mem_ram.sv
// Single-port 2^AWIDTH x 16 block RAM with per-byte write enables and a
// registered read port (data for addr appears one clock later).
//   clk   : clock
//   addr  : word address
//   we    : byte write enables, [1] = high byte, [0] = low byte
//   wdata : write data
//   rdata : registered read data
module unibus_mem_ram #(
  parameter int unsigned AWIDTH = 12
) (
  input  logic              clk,
  input  logic [AWIDTH-1:0] addr,
  input  logic [1:0]        we,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem [0:(1<<AWIDTH)-1];
  logic [15:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we[0]) mem[addr][7:0]  <= wdata[7:0];
    if (we[1]) mem[addr][15:8] <= wdata[15:8];
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/unibus_mem_slave.sv
// Unibus slave memory answering DATI/DATIP/DATO/DATOB inside a programmable
// window, with an ARM register port for configuration and direct RAM access.
//   CLOCK, RESET          : clock, synchronous active-high reset
//   armwrite/armwaddr/armwdata : ARM register write port
//   armraddr/armrdata     : ARM register read port (combinational)
//   a_in_h, c_in_h, d_in_h, msyn_in_h, init_in_h : Unibus inputs
//   d_out_h, ssyn_out_h   : Unibus data out (0 when idle) and slave sync
module unibus_mem_slave
  import unibus_mem_slave_pkg::*;
#(
  parameter int unsigned RAM_AWIDTH = 12,
  parameter int unsigned DESKEW_CYC = 8,
  parameter int unsigned SETUP_CYC  = 8
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [2:0]  armraddr,
  input  logic [2:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic [17:0] a_in_h,
  input  logic [1:0]  c_in_h,
  input  logic [15:0] d_in_h,
  input  logic        msyn_in_h,
  input  logic        init_in_h,
  output logic [15:0] d_out_h,
  output logic        ssyn_out_h
);

  localparam int unsigned WIN_W = 17 - RAM_AWIDTH;

  state_e                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  enable_q, enable_d;
  logic [4:0]            base_q, base_d;
  logic                  busy_q, busy_d;
  logic                  wr_q, wr_d;
  logic [RAM_AWIDTH-1:0] waddr_q, waddr_d;
  logic [15:0]           data_q, data_d;
  logic [31:0]           count_q, count_d;
  logic [1:0]            ctl_q, ctl_d;
  logic [15:0]           wd_q, wd_d;
  logic [RAM_AWIDTH-1:0] idx_q, idx_d;
  logic                  a0_q, a0_d;
  logic                  ssyn_q, ssyn_d;
  logic [15:0]           dout_q, dout_d;

  logic [RAM_AWIDTH-1:0] ram_addr;
  logic [1:0]            ram_we;
  logic [15:0]           ram_wdata, ram_rdata;

  logic [17:0] a_field, win_mask, base_ext;
  logic        bus_match;
  logic        unused_bits;

  assign unused_bits = ^armwdata;

  // Base is compared against the address bits above the window, truncated
  // or zero-extended to that field's width.
  assign a_field   = a_in_h >> (RAM_AWIDTH + 1);
  assign win_mask  = (18'd1 << WIN_W) - 18'd1;
  assign base_ext  = {13'd0, base_q} & win_mask;
  assign bus_match = enable_q & msyn_in_h & (a_in_h[17:13] != IO_PAGE)
                   & (a_field == base_ext);

  unibus_mem_ram #(.AWIDTH(RAM_AWIDTH)) u_ram (
    .clk   (CLOCK),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    enable_d  = enable_q;
    base_d    = base_q;
    busy_d    = busy_q;
    wr_d      = wr_q;
    waddr_d   = waddr_q;
    data_d    = data_q;
    count_d   = count_q;
    ctl_d     = ctl_q;
    wd_d      = wd_q;
    idx_d     = idx_q;
    a0_d      = a0_q;
    ssyn_d    = ssyn_q;
    dout_d    = dout_q;
    ram_addr  = idx_q;
    ram_we    = '0;
    ram_wdata = wd_q;

    if (armwrite) begin
      case (armwaddr)
        3'd1: begin
          enable_d = armwdata[31];
          base_d   = armwdata[4:0];
        end
        3'd2: if (!busy_q) begin
          busy_d  = armwdata[31];
          wr_d    = armwdata[30];
          waddr_d = armwdata[RAM_AWIDTH-1:0];
        end
        3'd3: if (!busy_q) data_d = armwdata[15:0];
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        ram_addr  = waddr_q;
        ram_wdata = data_q;
        if (bus_match) begin
          state_d = S_DESKEW;
        end else if (busy_q) begin
          ram_we  = wr_q ? 2'b11 : 2'b00;
          state_d = S_ARMDONE;
        end
      end
      S_DESKEW: begin
        if (!msyn_in_h) begin
          state_d = S_IDLE;
        end else if (cnt_q == 16'(DESKEW_CYC - 1)) begin
          ctl_d   = c_in_h;
          wd_d    = d_in_h;
          idx_d   = a_in_h[RAM_AWIDTH:1];
          a0_d    = a_in_h[0];
          cnt_d   = '0;
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ACCESS: begin
        if (ctl_q[1]) begin
          // The write is committed regardless of a late MSYN drop
          if (ctl_q == CTL_DATOB) ram_we = a0_q ? 2'b10 : 2'b01;
          else                    ram_we = 2'b11;
          if (msyn_in_h) begin
            ssyn_d  = 1'b1;
            count_d = count_q + 32'd1;
            state_d = S_REPLY;
          end else begin
            state_d = S_IDLE;
          end
        end else if (!msyn_in_h) begin
          dout_d  = '0;
          state_d = S_IDLE;
        end else if (cnt_q == 16'd0) begin
          // first cycle issues the read; RAM data is valid on the second
          cnt_d = 16'd1;
        end else begin
          dout_d  = ram_rdata;
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (!msyn_in_h) begin
          dout_d  = '0;
          state_d = S_IDLE;
        end else if (cnt_q == 16'(SETUP_CYC - 1)) begin
          ssyn_d  = 1'b1;
          count_d = count_q + 32'd1;
          state_d = S_REPLY;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_REPLY: begin
        if (!msyn_in_h) begin
          ssyn_d  = 1'b0;
          dout_d  = '0;
          state_d = S_IDLE;
        end
      end
      S_ARMDONE: begin
        if (!wr_q) data_d = ram_rdata;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Bus init aborts the cycle in progress; ARM configuration survives
    if (init_in_h) begin
      state_d = S_IDLE;
      ssyn_d  = 1'b0;
      dout_d  = '0;
      ram_we  = '0;
      count_d = count_q;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      enable_q <= 1'b0;
      base_q   <= '0;
      busy_q   <= 1'b0;
      wr_q     <= 1'b0;
      waddr_q  <= '0;
      data_q   <= '0;
      count_q  <= '0;
      ctl_q    <= '0;
      wd_q     <= '0;
      idx_q    <= '0;
      a0_q     <= 1'b0;
      ssyn_q   <= 1'b0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      enable_q <= enable_d;
      base_q   <= base_d;
      busy_q   <= busy_d;
      wr_q     <= wr_d;
      waddr_q  <= waddr_d;
      data_q   <= data_d;
      count_q  <= count_d;
      ctl_q    <= ctl_d;
      wd_q     <= wd_d;
      idx_q    <= idx_d;
      a0_q     <= a0_d;
      ssyn_q   <= ssyn_d;
      dout_q   <= dout_d;
    end
  end

  always_comb begin
    case (armraddr)
      3'd0:    armrdata = ID_VALUE;
      3'd1:    armrdata = {enable_q, 26'd0, base_q};
      3'd2:    armrdata = {busy_q, wr_q, {(30-RAM_AWIDTH){1'b0}}, waddr_q};
      3'd3:    armrdata = {16'd0, data_q};
      3'd4:    armrdata = count_q;
      default: armrdata = BAD_REG;
    endcase
  end

  assign ssyn_out_h = ssyn_q;
  assign d_out_h    = dout_q;

endmodule

// File: tb/tb_unibus_mem_slave.sv
// Self-checking bench for unibus_mem_slave: directed scenarios followed by
// randomized bus and ARM traffic, checked against a word-array memory model.
module tb_unibus_mem_slave;

  localparam int unsigned AW     = 12;
  localparam int unsigned DSK    = 8;
  localparam int unsigned STP    = 8;
  localparam int unsigned BUDGET = DSK + STP + 3;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        armwrite;
  logic [2:0]  armraddr, armwaddr;
  logic [31:0] armwdata, armrdata;
  logic [17:0] a_in_h;
  logic [1:0]  c_in_h;
  logic [15:0] d_in_h, d_out_h;
  logic        msyn_in_h, init_in_h, ssyn_out_h;

  unibus_mem_slave #(.RAM_AWIDTH(AW), .DESKEW_CYC(DSK), .SETUP_CYC(STP)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
    .armwdata(armwdata), .armrdata(armrdata),
    .a_in_h(a_in_h), .c_in_h(c_in_h), .d_in_h(d_in_h),
    .msyn_in_h(msyn_in_h), .init_in_h(init_in_h),
    .d_out_h(d_out_h), .ssyn_out_h(ssyn_out_h)
  );

  always #5 CLOCK = ~CLOCK;

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  bit                m_en;
  int unsigned       m_base;
  logic [15:0]       m_mem [int unsigned];
  int unsigned       m_count;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit hits(input logic [17:0] a);
    int unsigned ai = a;
    int unsigned lo = m_base * 8192;
    if (!m_en) return 0;
    if (ai >= 'o760000) return 0;
    return (ai >= lo) && (ai < lo + 8192);
  endfunction

  function automatic int unsigned widx(input logic [17:0] a);
    return (int'(a) / 2) % (1 << AW);
  endfunction

  task automatic arm_wr(input logic [2:0] r, input logic [31:0] v);
    @(negedge CLOCK);
    armwrite = 1'b1; armwaddr = r; armwdata = v;
    @(negedge CLOCK);
    armwrite = 1'b0;
  endtask

  task automatic arm_rd(input logic [2:0] r, output logic [31:0] v);
    @(negedge CLOCK);
    armraddr = r;
    #1 v = armrdata;
  endtask

  task automatic set_cfg(input bit en, input int unsigned base);
    arm_wr(3'd1, {en, 26'd0, 5'(base)});
    m_en = en; m_base = base;
  endtask

  task automatic bus_cycle(input string tag, input logic [17:0] a, input logic [1:0] c,
                           input logic [15:0] d, output logic [15:0] got);
    bit          hit = hits(a);
    int unsigned idx = widx(a);
    bit          seen = 0;
    logic [15:0] dor = '0;
    got = '0;
    @(negedge CLOCK);
    a_in_h = a; c_in_h = c; d_in_h = d; msyn_in_h = 1'b1;
    for (int i = 0; i < int'(BUDGET); i++) begin
      @(negedge CLOCK);
      dor |= d_out_h;
      if (ssyn_out_h) begin
        seen = 1; got = d_out_h;
        break;
      end
    end
    chk({tag, "_ssyn"}, 32'(seen), 32'(hit));
    if (hit) begin
      m_count++;
      if (c < 2) begin
        if (m_mem.exists(idx)) chk({tag, "_rdata"}, 32'(got), 32'(m_mem[idx]));
      end else begin
        chk({tag, "_wr_dout"}, 32'(got), 32'd0);
        if (c == 2) m_mem[idx] = d;
        else if (m_mem.exists(idx)) begin
          if (a[0]) m_mem[idx] = 16'((m_mem[idx] % 256) + (d / 256) * 256);
          else      m_mem[idx] = 16'((m_mem[idx] / 256) * 256 + (d % 256));
        end
      end
    end else begin
      chk({tag, "_miss_dout"}, 32'(dor), 32'd0);
    end
    @(negedge CLOCK);
    msyn_in_h = 1'b0;
    @(negedge CLOCK);
    chk({tag, "_release"}, {15'd0, ssyn_out_h, d_out_h}, 32'd0);
  endtask

  task automatic arm_access(input string tag, input bit wr, input int unsigned idx,
                            input logic [15:0] dat);
    logic [31:0] v;
    if (wr) arm_wr(3'd3, {16'd0, dat});
    arm_wr(3'd2, {1'b1, wr, 18'd0, 12'(idx)});
    v = 32'hFFFFFFFF;
    for (int i = 0; i < 20; i++) begin
      arm_rd(3'd2, v);
      if (!v[31]) break;
    end
    chk({tag, "_reg2"}, v, {1'b0, wr, 18'd0, 12'(idx)});
    if (wr) m_mem[idx] = dat;
    else if (m_mem.exists(idx)) begin
      arm_rd(3'd3, v);
      chk({tag, "_reg3"}, v, {16'd0, m_mem[idx]});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [15:0] got;
    bit          seen;
    RESET = 1'b1; armwrite = 1'b0; armraddr = '0; armwaddr = '0; armwdata = '0;
    a_in_h = '0; c_in_h = '0; d_in_h = '0; msyn_in_h = 1'b0; init_in_h = 1'b0;
    m_en = 0; m_base = 0; m_count = 0;
    repeat (3) @(negedge CLOCK);
    RESET = 1'b0;

    // reset state
    arm_rd(3'd0, v); chk("id", v, 32'h554D1005);
    arm_rd(3'd1, v); chk("rst_cfg", v, 32'd0);
    arm_rd(3'd2, v); chk("rst_reg2", v, 32'd0);
    arm_rd(3'd4, v); chk("rst_count", v, 32'd0);
    arm_rd(3'd6, v); chk("bad_reg", v, 32'hDEADBEEF);
    chk("rst_bus", {15'd0, ssyn_out_h, d_out_h}, 32'd0);

    // disabled: no answer
    bus_cycle("disabled", 18'o040100, 2'd0, 16'd0, got);

    // write/read
    set_cfg(1, 2);
    bus_cycle("dato", 18'o040100, 2'd2, 16'o123456, got);
    bus_cycle("dati", 18'o040100, 2'd0, 16'd0, got);
    chk("dati_const", 32'(got), 32'(16'o123456));
    arm_rd(3'd4, v); chk("count2", v, 32'd2);

    // byte write
    bus_cycle("fill", 18'o040102, 2'd2, 16'o177777, got);
    bus_cycle("datob", 18'o040103, 2'd3, 16'o000400, got);
    bus_cycle("datip", 18'o040102, 2'd1, 16'd0, got);
    chk("byte_const", 32'(got), 32'(16'o000777));

    // misses
    bus_cycle("miss_win", 18'o060000, 2'd0, 16'd0, got);
    set_cfg(1, 31);
    bus_cycle("miss_io", 18'o777570, 2'd0, 16'd0, got);
    set_cfg(1, 2);
    arm_rd(3'd4, v); chk("miss_count", v, 32'(m_count));

    // abort in deskew
    bus_cycle("pre_abort", 18'o040200, 2'd2, 16'o070707, got);
    @(negedge CLOCK);
    a_in_h = 18'o040200; c_in_h = 2'd2; d_in_h = 16'o111111; msyn_in_h = 1'b1;
    seen = 0;
    repeat (4) begin @(negedge CLOCK); seen |= ssyn_out_h; end
    msyn_in_h = 1'b0;
    repeat (BUDGET) begin @(negedge CLOCK); seen |= ssyn_out_h; end
    chk("abort_ssyn", 32'(seen), 32'd0);
    bus_cycle("post_abort", 18'o040200, 2'd0, 16'd0, got);
    chk("abort_const", 32'(got), 32'(16'o070707));

    // ARM port
    arm_access("arm_w", 1, 'h40, 16'h1234);
    arm_access("arm_r", 0, 'h40, 16'h0);
    arm_rd(3'd3, v); chk("arm_r_const", v, 32'h1234);
    bus_cycle("arm_bus", 18'o040200, 2'd0, 16'd0, got);
    chk("arm_bus_const", 32'(got), 32'h1234);

    // priority: ARM go and matching MSYN in the same cycle
    @(negedge CLOCK);
    a_in_h = 18'o040300; c_in_h = 2'd2; d_in_h = 16'hBEEF; msyn_in_h = 1'b1;
    armwrite = 1'b1; armwaddr = 3'd2; armwdata = {1'b1, 1'b0, 18'd0, 12'h060};
    @(negedge CLOCK);
    armwrite = 1'b0;
    seen = 0;
    for (int i = 0; i < int'(BUDGET); i++) begin
      if (ssyn_out_h) begin seen = 1; break; end
      @(negedge CLOCK);
    end
    chk("prio_ssyn", 32'(seen), 32'd1);
    arm_rd(3'd2, v); chk("prio_busy_held", 32'(v[31]), 32'd1);
    msyn_in_h = 1'b0;
    m_count++; m_mem['h60] = 16'hBEEF;
    for (int i = 0; i < 20; i++) begin
      arm_rd(3'd2, v);
      if (!v[31]) break;
    end
    chk("prio_done", 32'(v[31]), 32'd0);
    arm_rd(3'd3, v); chk("prio_reg3", v, 32'h0000BEEF);

    // init during REPLY
    @(negedge CLOCK);
    a_in_h = 18'o040100; c_in_h = 2'd0; msyn_in_h = 1'b1;
    seen = 0;
    for (int i = 0; i < int'(BUDGET); i++) begin
      @(negedge CLOCK);
      if (ssyn_out_h) begin seen = 1; break; end
    end
    chk("init_pre_ssyn", 32'(seen), 32'd1);
    m_count++;
    init_in_h = 1'b1;
    @(negedge CLOCK);
    chk("init_clear", {15'd0, ssyn_out_h, d_out_h}, 32'd0);
    init_in_h = 1'b0; msyn_in_h = 1'b0;
    arm_rd(3'd1, v); chk("init_cfg", v, {1'b1, 26'd0, 5'd2});
    bus_cycle("post_init", 18'o040100, 2'd0, 16'd0, got);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      int unsigned op = $urandom_range(0, 5);
      logic [17:0] a;
      if ($urandom_range(0, 3) == 0) a = 18'($urandom);
      else a = 18'(18'o040000 + 2 * $urandom_range(0, 15) + $urandom_range(0, 1));
      if (op < 4) bus_cycle("rnd_bus", a, 2'(op), 16'($urandom), got);
      else arm_access("rnd_arm", op == 4, $urandom_range(0, 15), 16'($urandom));
    end
    arm_rd(3'd4, v); chk("final_count", v, 32'(m_count));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/unibus_mem_slave.md
Name: unibus_mem_slave

Overview:
- Unibus slave memory: answers DATI/DATIP/DATO/DATOB cycles that fall inside a programmable address window.
- Backed by on-chip 16-bit block RAM.
- It is the responding end of the DMA master cycles issued by the switch/light block: it receives MSYN and returns SSYN.
- The ARM side configures the window and can read/write the RAM through a register port.

Parameters:
- RAM_AWIDTH, 12, log2 of RAM word count (default 4K words = 8KB window).
- DESKEW_CYC, 8, clock cycles from MSYN seen to decode/act (address/data deskew).
- SETUP_CYC, 8, clock cycles read data is driven before SSYN is asserted.

Ports:
- CLOCK  in  1  system clock
- RESET  in  1  synchronous active-high reset
- armwrite  in  1  ARM register write strobe
- armraddr  in  3  ARM read register select
- armwaddr  in  3  ARM write register select
- armwdata  in  32  ARM write data
- armrdata  out  32  ARM read data (combinational on armraddr)
- a_in_h  in  18  Unibus address
- c_in_h  in  2  Unibus control: 0 DATI, 1 DATIP, 2 DATO, 3 DATOB
- d_in_h  in  16  Unibus data in
- msyn_in_h  in  1  master sync
- init_in_h  in  1  bus init
- d_out_h  out  16  Unibus data out; OR-combined externally, 0 when idle
- ssyn_out_h  out  1  slave sync

Behaviour:
- Clocking and reset:
  - One clock, CLOCK.
  - Reset is synchronous, active-high, on RESET.
- Reset / init:
  - RESET clears all ARM registers: enable=0, base=0, count=0, busy=0.
  - RESET or init_in_h forces state IDLE, ssyn_out_h=0, d_out_h=0, and cancels any pending RAM write. RAM contents are untouched.
- ARM registers:
  - 0: ID, read 32'h554D1005.
  - 1: {enable[31], 26'b0, base[4:0]}. Base is in window-size units: the match is a_in_h[17:RAM_AWIDTH+1]==base, truncated or extended to the field width.
  - 2: {busy[31], wr[30], 30-RAM_AWIDTH zero bits, waddr}. Writing with bit31=1 starts an ARM access; writes while busy=1 are ignored.
  - 3: {16'b0, data}. Write data for an ARM write; result of an ARM read.
  - 4: completed bus-cycle count, 32-bit, wraps.
  - Others read 32'hDEADBEEF.
- Match:
  - Requires enable, msyn_in_h, and an address in the window.
  - Never matches when a_in_h[17:13]==5'b11111 (I/O page).
  - Word index = a_in_h[RAM_AWIDTH:1].
- States:
  - IDLE: if msyn_in_h & match, go to DESKEW with counter=0. Otherwise, if busy, perform the ARM access and go to ARMDONE. The bus has priority when both are requested in the same cycle.
  - DESKEW: count to DESKEW_CYC-1. If msyn drops, return to IDLE (no RAM write, no SSYN). Then latch c_in_h, d_in_h and the index, and go to ACCESS.
  - ACCESS, read (c_in_h[1]=0):
    - Issue RAM read (1-cycle latency); next cycle drive d_out_h=RAM data and go to SETUP.
    - DATIP is treated as DATI.
  - ACCESS, write:
    - Write RAM this cycle. DATO writes both bytes. DATOB writes the high byte if a[0]=1, else the low byte.
    - Go to REPLY.
  - SETUP: hold d_out_h for SETUP_CYC cycles, then go to REPLY.
  - REPLY:
    - ssyn_out_h=1; increment count.
    - Hold until msyn_in_h=0, then in that same cycle clear ssyn_out_h and d_out_h and go to IDLE.
    - If msyn drops during ACCESS or SETUP: clear d_out_h, no SSYN, return to IDLE. A write already performed in ACCESS stands.
  - ARMDONE: read result is latched into reg 3; busy=0; go to IDLE.
- DATO with msyn held through ACCESS: exactly one RAM write per bus cycle.
- An ARM config write during an active cycle takes effect at the next IDLE match.

Decomposition:
- Shared package holds:
  - Control codes DATI/DATIP/DATO/DATOB.
  - ID constant.
  - I/O-page prefix 5'b11111.
  - State enum: IDLE, DESKEW, ACCESS, SETUP, REPLY, ARMDONE.
- One sub-module, unibus_mem_ram: single-port RAM, 2^RAM_AWIDTH x 16, 2-bit byte write enable, registered read.

Test Plan:
- Bus write/read:
  - Stimulus: enable=1, base=2 (window 040000-057776). DATO a=040100, d=0o123456; drop MSYN after SSYN.
  - Then DATI a=040100.
  - Required: SSYN within DESKEW_CYC+SETUP_CYC+3 cycles; d_out_h=0o123456 while SSYN=1; d_out_h=0 the cycle after MSYN drops; count=2.
- Byte write:
  - Stimulus: after writing 0o177777 at 040102, DATOB a=040103, d=0o000400.
  - Required: DATI returns 0o000777.
- Miss:
  - Stimulus: DATI a=060000; separately DATI a=777570 with base=5'b11111.
  - Required: ssyn_out_h and d_out_h stay 0; count unchanged.
- Abort:
  - Stimulus: DATO a=040200 with MSYN dropped at DESKEW cycle 3.
  - Required: no SSYN; RAM word unchanged on a later DATI.
- ARM port:
  - Stimulus: reg3=0x1234, reg2={1,1,..,0x40}; poll busy; then reg2 read of 0x40.
  - Required: reg3=0x1234; bus DATI a=040200 returns 0x1234.
- Priority and init:
  - Stimulus: ARM go and matching MSYN in the same cycle; then init_in_h pulsed during REPLY.
  - Required: the bus cycle completes first, then the ARM access. Init clears ssyn_out_h and d_out_h the next cycle, state returns to IDLE, and config is retained.
